// File: rtl/ob_rd_streamer_if.sv
// Outbound read streamer bus bundle.
// Groups the descriptor handshake, outbound RAM read port, transmit stream and status.
//   master: the streamer (accepts descriptors, reads RAM, drives the stream)
//   slave : the environment (issues descriptors, serves RAM reads, sinks the stream)
interface ob_rd_streamer_if;
  logic         DescValid;
  logic         DescReady;
  logic [31:0]  DescAddr;
  logic [8:0]   DescLen;
  logic         ObRdEn;
  logic [31:0]  ObRdAddr;
  logic [127:0] ObRdData;
  logic [127:0] TxData;
  logic         TxValid;
  logic         TxReady;
  logic         TxLast;
  logic         Busy;
  logic         Done;

  modport master (
    input  DescValid, DescAddr, DescLen, ObRdData, TxReady,
    output DescReady, ObRdEn, ObRdAddr, TxData, TxValid, TxLast, Busy, Done
  );

  modport slave (
    output DescValid, DescAddr, DescLen, ObRdData, TxReady,
    input  DescReady, ObRdEn, ObRdAddr, TxData, TxValid, TxLast, Busy, Done
  );
endinterface

// File: rtl/ob_rd_streamer.sv
// Outbound RAM read streamer.
// Accepts a (start beat address, beat count) descriptor, reads the beats from a fixed-latency
// outbound RAM and streams them as 128-bit beats with TxLast on the final one.
// Ports:
//   clk   - single rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - ob_rd_streamer_if.master: descriptor handshake, RAM read port, Tx stream,
//           Busy (not idle) and Done (one-cycle completion pulse)
module ob_rd_streamer #(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  ob_rd_streamer_if.master bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state;
  logic [31:0]       baseAddr;
  logic [8:0]        len;
  logic [8:0]        issued;
  logic [8:0]        sent;
  logic              rdEn;
  logic [31:0]       rdAddr;
  logic [RD_LAT-1:0] vldPipe;
  logic [127:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [PtrW:0]     count;
  logic              descReady;
  logic              done;

  logic              descFire;
  logic              rdFire;
  logic              lastIssue;
  logic              push;
  logic              pop;
  logic              txValid;
  logic              txLast;
  logic [CntW-1:0]   inFlight;

  // Reads committed but not yet in the FIFO: the registered strobe plus the valid pipe.
  always_comb begin
    inFlight = CntW'(rdEn);
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inFlight = inFlight + CntW'(vldPipe[i]);
    end
  end

  assign txValid   = (count != '0);
  assign txLast    = txValid && (sent == len - 9'd1);
  assign descFire  = bus.DescValid && descReady;
  // Credit check: never commit more reads than the FIFO can absorb without any pop.
  assign rdFire    = (state == StRun) && (issued < len) &&
                     ((inFlight + CntW'(count)) < CntW'(FIFO_DEPTH));
  assign lastIssue = rdFire && (issued + 9'd1 == len);
  assign push      = vldPipe[RD_LAT-1];
  assign pop       = txValid && bus.TxReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      baseAddr  <= '0;
      len       <= '0;
      issued    <= '0;
      sent      <= '0;
      rdEn      <= 1'b0;
      rdAddr    <= '0;
      vldPipe   <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      descReady <= 1'b0;
      done      <= 1'b0;
    end else begin
      rdEn    <= rdFire;
      vldPipe <= (vldPipe << 1) | RD_LAT'(rdEn);
      done    <= 1'b0;
      if (rdFire) begin
        rdAddr <= baseAddr + 32'(issued);
        issued <= issued + 9'd1;
      end
      if (push) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrW'(1);
        sent  <= sent + 9'd1;
      end
      count <= count + (PtrW+1)'(push) - (PtrW+1)'(pop);

      unique case (state)
        StIdle: begin
          if (descFire) begin
            baseAddr <= bus.DescAddr;
            len      <= bus.DescLen;
            issued   <= '0;
            sent     <= '0;
            if (bus.DescLen == '0) begin
              done <= 1'b1;
            end else begin
              state     <= StRun;
              descReady <= 1'b0;
            end
          end else begin
            descReady <= 1'b1;
          end
        end
        StRun: begin
          // Leave on the edge that issues the final read, so a 1-beat descriptor spends one
          // cycle here.
          if (lastIssue) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if (pop && txLast) begin
            state     <= StIdle;
            done      <= 1'b1;
            descReady <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Data array needs no reset: it is only observed through txValid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= bus.ObRdData;
    end
  end

  assign bus.DescReady = descReady;
  assign bus.ObRdEn    = rdEn;
  assign bus.ObRdAddr  = rdAddr;
  assign bus.TxValid   = txValid;
  assign bus.TxData    = txValid ? mem[rdPtr] : '0;
  assign bus.TxLast    = txLast;
  assign bus.Busy      = (state != StIdle);
  assign bus.Done      = done;
endmodule
